tf_fetch_ctrl: RTL and testbench
================================

TF_FETCH_CTRL -- requirements
Module: tf_fetch_ctrl

Interface
REQ-001 Parameters: DATA_W, default 64, width of one twiddle-factor word group; ROW_LEN, default 256, entries per row; ROW_NUM, default 4, rows per pass.
REQ-002 clk  input  1  clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse, begins a pass; honoured only in IDLE.
REQ-005 row_rdy  input  1  one-cycle pulse from the TF generator: one full row has been written into the current write bank.
REQ-006 buf_full  output  1  both ping-pong banks hold unread rows; the generator SHALL stall while high.
REQ-007 ren  output  1  TF buffer read enable.
REQ-008 addr_r  output  9  TF buffer read address {bank, idx[7:0]}.
REQ-009 rdata  input  DATA_W  TF buffer read data, valid exactly 1 cycle after ren.
REQ-010 tf_vld  output  1  tf_data valid toward the butterfly array.
REQ-011 tf_rdy  input  1  butterfly array accepts; transfer = tf_vld & tf_rdy.
REQ-012 tf_data  output  DATA_W  twiddle-factor word.
REQ-013 tf_last  output  1  qualifies the transfer of idx ROW_LEN-1 of a row.
REQ-014 row_idx  output  2  row number (0..ROW_NUM-1) of the word on tf_data.
REQ-015 done  output  1  one-cycle pulse, pass complete.
REQ-016 err  output  1  sticky overflow flag.
REQ-017 stall_cnt  output  16  back-pressure counter (see Configuration).

Function
REQ-018 FSM states IDLE, WAIT, READ, FLUSH; IDLE->WAIT on start; WAIT->READ when rows_avail>0; READ->WAIT after last ren of a row if rows remain and rows_avail becomes 0; READ->FLUSH after last ren of row ROW_NUM-1; FLUSH->IDLE when output FIFO empty and no read in flight.
REQ-019 rows_avail counter 0..2: +1 on row_rdy, -1 on bank release, unchanged on both in same cycle; buf_full = (rows_avail==2), registered.
REQ-020 row_rdy while rows_avail==2 and no release in same cycle SHALL set err and leave rows_avail at 2.
REQ-021 Read-side output buffer: 2-entry FIFO; ren asserted only when FIFO occupancy + in-flight reads - pop this cycle < 2 and state is READ.
REQ-022 idx increments per ren, wraps ROW_LEN-1->0; bank toggles on wrap, starting at 0 per pass.
REQ-023 Bank release (rows_avail decrement) occurs the cycle after the ren of idx ROW_LEN-1.
REQ-024 Latency: first tf_vld asserts 2 cycles after first ren of a pass with tf_rdy high.
REQ-025 tf_vld, once high, SHALL hold with tf_data, tf_last, row_idx stable until transfer.
REQ-026 With tf_rdy held high and rows available, one transfer per cycle, no bubbles within or across rows.
REQ-027 done pulses the cycle after FSM enters IDLE from FLUSH; exactly ROW_NUM*ROW_LEN transfers per pass.
REQ-028 start outside IDLE ignored; row_rdy in IDLE counted (generator may run ahead of start).
REQ-029 start in IDLE clears idx, bank, row_idx; rows_avail and err are not cleared by start.

Reset
REQ-030 rst_n low: state IDLE, FIFO empty, rows_avail 0, all outputs 0 (buf_full, ren, addr_r, tf_vld, tf_data, tf_last, row_idx, done, err, stall_cnt).
REQ-031 Reset mid-pass aborts immediately; no done is emitted; in-flight read data is discarded.

Configuration
REQ-032 Macro TF_FETCH_STALL_CNT_EN defined: stall_cnt counts cycles with tf_vld & !tf_rdy, saturates at 16'hFFFF, cleared by start in IDLE.
REQ-033 Macro undefined: stall_cnt driven constant 0, counter logic absent; all other behaviour identical.

Verification
REQ-034 Default params, row_rdy x4 spaced 300 cycles, tf_rdy=1 -> 1024 transfers, addr_r 0x000..0x0FF then 0x100..0x1FF alternating, tf_last on each idx 255, row_idx 0..3, one done.
REQ-035 Two row_rdy before start -> buf_full=1; third row_rdy -> err=1, rows_avail stays 2.
REQ-036 tf_rdy random 50% -> tf_data sequence matches memory model, no drop/duplicate, ren never issued with FIFO+in-flight at 2.
REQ-037 row_rdy coincident with bank release -> rows_avail unchanged, buf_full unchanged.
REQ-038 rst_n pulsed low at transfer 500 -> all outputs 0 next cycle, no done; new start completes full 1024-transfer pass.
REQ-039 TF_FETCH_STALL_CNT_EN defined, tf_rdy low 10 cycles while tf_vld high -> stall_cnt=10; undefined -> stall_cnt=0.

Source files
------------

// File: rtl/tf_fetch_ctrl.sv
// Twiddle-factor fetch controller: ping-pong bank reader feeding a 2-entry output FIFO.
// Optional macro TF_FETCH_STALL_CNT_EN enables the back-pressure stall counter.
module tf_fetch_ctrl #(
    parameter int DATA_W  = 64,
    parameter int ROW_LEN = 256,
    parameter int ROW_NUM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              row_rdy,
    output logic              buf_full,
    output logic              ren,
    output logic [8:0]        addr_r,
    input  logic [DATA_W-1:0] rdata,
    output logic              tf_vld,
    input  logic              tf_rdy,
    output logic [DATA_W-1:0] tf_data,
    output logic              tf_last,
    output logic [1:0]        row_idx,
    output logic              done,
    output logic              err,
    output logic [15:0]       stall_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [7:0] IDX_LAST = 8'(ROW_LEN - 1);
    localparam logic [1:0] ROW_LAST = 2'(ROW_NUM - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] idx;
    logic       bank;
    logic [1:0] rd_row;

    logic [1:0] rows_avail;
    logic [1:0] rows_nxt;
    logic [1:0] avail_eff;
    logic       ovf;
    logic       rel_q;

    logic       rd_vld_q;
    logic       rd_last_q;
    logic [1:0] rd_row_q;

    logic [DATA_W-1:0] f_data0, f_data1;
    logic              f_last0, f_last1;
    logic [1:0]        f_row0, f_row1;
    logic              wp, rp;
    logic [1:0]        cnt;

    logic       pop;
    logic       push;
    logic       last_rd;
    logic       go;
    logic [2:0] occ;

    assign pop     = tf_vld & tf_rdy;
    assign push    = rd_vld_q;
    assign occ     = 3'(cnt) + 3'(rd_vld_q) - 3'(pop);
    assign ren     = (state == S_READ) && (occ < 3'd2);
    assign last_rd = ren && (idx == IDX_LAST);
    assign addr_r  = {bank, idx};
    assign go      = start && (state == S_IDLE);

    // Rows still usable once a pending bank release has been applied.
    assign avail_eff = rows_avail - 2'(rel_q);

    assign tf_vld  = (cnt != 2'd0);
    assign tf_data = tf_vld ? (rp ? f_data1 : f_data0) : '0;
    assign tf_last = tf_vld & (rp ? f_last1 : f_last0);
    assign row_idx = tf_vld ? (rp ? f_row1 : f_row0) : 2'd0;

    // Pass sequencing: wait for rows, read them, drain the FIFO.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT:  if (avail_eff != 2'd0) state_nxt = S_READ;
            S_READ: begin
                if (last_rd) begin
                    if (rd_row == ROW_LAST) begin
                        state_nxt = S_FLUSH;
                    end else if (!(avail_eff == 2'd2 || row_rdy)) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            default: if (cnt == 2'd0 && !rd_vld_q) state_nxt = S_IDLE;
        endcase
    end

    // Written-row accounting: row_rdy adds, bank release subtracts.
    always_comb begin
        rows_nxt = rows_avail;
        ovf      = 1'b0;
        if (row_rdy && !rel_q) begin
            if (rows_avail == 2'd2) ovf = 1'b1;
            else rows_nxt = rows_avail + 2'd1;
        end else if (!row_rdy && rel_q && rows_avail != 2'd0) begin
            rows_nxt = rows_avail - 2'd1;
        end
    end

    // FSM state and end-of-pass pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_FLUSH) && (state_nxt == S_IDLE);
        end
    end

    // Row counter, full flag, sticky overflow and release timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_avail <= 2'd0;
            buf_full   <= 1'b0;
            err        <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            rows_avail <= rows_nxt;
            buf_full   <= (rows_nxt == 2'd2);
            rel_q      <= last_rd;
            if (ovf) err <= 1'b1;
        end
    end

    // Read address generation across banks and rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= 8'd0;
            bank   <= 1'b0;
            rd_row <= 2'd0;
        end else if (go) begin
            idx    <= 8'd0;
            bank   <= 1'b0;
            rd_row <= 2'd0;
        end else if (ren) begin
            if (last_rd) begin
                idx    <= 8'd0;
                bank   <= ~bank;
                rd_row <= (rd_row == ROW_LAST) ? 2'd0 : rd_row + 2'd1;
            end else begin
                idx <= idx + 8'd1;
            end
        end
    end

    // Side information travelling with each in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_row_q  <= 2'd0;
        end else begin
            rd_vld_q  <= ren;
            rd_last_q <= last_rd;
            rd_row_q  <= rd_row;
        end
    end

    // Two-entry output FIFO toward the butterfly array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_data0 <= '0;
            f_data1 <= '0;
            f_last0 <= 1'b0;
            f_last1 <= 1'b0;
            f_row0  <= 2'd0;
            f_row1  <= 2'd0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (push) begin
                if (wp) begin
                    f_data1 <= rdata;
                    f_last1 <= rd_last_q;
                    f_row1  <= rd_row_q;
                end else begin
                    f_data0 <= rdata;
                    f_last0 <= rd_last_q;
                    f_row0  <= rd_row_q;
                end
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

`ifdef TF_FETCH_STALL_CNT_EN
    // Saturating count of cycles the array refuses a valid word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (go) begin
            stall_cnt <= 16'd0;
        end else if (tf_vld && !tf_rdy && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_tf_fetch_ctrl.sv
// Directed bench for tf_fetch_ctrl with a bank memory model and a transfer monitor.
// Checks addresses, data order, hold, latency, full/err flags, reset abort and stall count.
module tb_tf_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        row_rdy;
    logic        buf_full;
    logic        ren;
    logic [8:0]  addr_r;
    logic [63:0] rdata = '0;
    logic        tf_vld;
    logic        tf_rdy;
    logic [63:0] tf_data;
    logic        tf_last;
    logic [1:0]  row_idx;
    logic        done;
    logic        err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [512];
    int  wseq = 0;
    int  rseq = 0;
    bit  wb = 0;
    bit  rel_prev = 0;
    bit  ren_s = 0;
    logic [8:0] addr_s = '0;

    int  cyc = 0;
    int  occ_m = 0;
    int  infl_m = 0;
    int  xfer = 0;
    int  lasts = 0;
    int  ren_cnt = 0;
    int  ren_cyc = 0;
    int  row0 = 0;
    int  lastpop = 0;
    int  done_cnt = 0;
    bit  have_ren = 0;
    bit  have_vld = 0;
    bit  nb_row = 0;
    bit  nb_x = 0;
    bit  abort = 0;
    bit  pv_vld = 0;
    bit  pv_rdy = 0;
    logic [63:0] pv_data = '0;
    logic        pv_last = 0;
    logic [1:0]  pv_row = 0;

    tf_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_rdy(row_rdy),
        .buf_full(buf_full), .ren(ren), .addr_r(addr_r), .rdata(rdata),
        .tf_vld(tf_vld), .tf_rdy(tf_rdy), .tf_data(tf_data),
        .tf_last(tf_last), .row_idx(row_idx), .done(done), .err(err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Read port of the TF buffer: data one cycle after ren.
    always @(posedge clk) begin
        if (ren_s) rdata <= mem[addr_s];
    end

    // Generator memory model and transfer monitor, sampled mid-cycle.
    always @(negedge clk) begin
        bit pop_b;
        logic [9:0] xb;
        logic [63:0] ex;
        cyc++;
        if (!rst_n) begin
            occ_m = 0; infl_m = 0; xfer = 0; lasts = 0; ren_cnt = 0;
            rseq = wseq; have_ren = 0; have_vld = 0; pv_vld = 0;
            wb = 0; rel_prev = 0; ren_s = 0;
        end else begin
            if (row_rdy && (!buf_full || rel_prev)) begin
                for (int i = 0; i < 256; i++) begin
                    mem[{wb, i[7:0]}] = {wseq[31:0], 23'd0, wb, i[7:0]};
                end
                wb = ~wb;
                wseq++;
            end
            rel_prev = ren && (addr_r[7:0] == 8'hFF);
            ren_s = ren;
            addr_s = addr_r;
            pop_b = tf_vld && tf_rdy;
            if (start) begin
                xfer = 0; lasts = 0; ren_cnt = 0;
                have_ren = 0; have_vld = 0;
            end
            if (ren) begin
                chk("ren_room", 64'((occ_m + infl_m - int'(pop_b)) >= 2), 0);
                chk("addr_r", 64'(addr_r), 64'(ren_cnt[8:0]));
                if (!have_ren) begin have_ren = 1; ren_cyc = cyc; end
                ren_cnt++;
            end
            if (tf_vld && !have_vld && have_ren) begin
                have_vld = 1;
                chk("latency", 64'(cyc - ren_cyc), 2);
            end
            if (pv_vld && !pv_rdy) begin
                chk("hold_vld", 64'(tf_vld), 1);
                chk("hold_data", tf_data, pv_data);
                chk("hold_last", 64'(tf_last), 64'(pv_last));
                chk("hold_row", 64'(row_idx), 64'(pv_row));
            end
            if (pop_b) begin
                xb = xfer[9:0];
                ex = {rseq[31:0], 23'd0, xb[8], xb[7:0]};
                chk("tf_data", tf_data, ex);
                chk("tf_last", 64'(tf_last), 64'(xb[7:0] == 8'hFF));
                chk("row_idx", 64'(row_idx), 64'(xb[9:8]));
                if (xb[7:0] == 8'd0) row0 = cyc;
                if (nb_row && tf_last) chk("row_bubble", 64'(cyc - row0), 255);
                if (nb_x && xb[7:0] == 8'd0 && xfer != 0)
                    chk("xrow_bubble", 64'(cyc - lastpop), 1);
                if (tf_last) begin rseq++; lasts++; end
                lastpop = cyc;
                xfer++;
            end
            if (done) done_cnt++;
            pv_vld = tf_vld; pv_rdy = tf_rdy; pv_data = tf_data;
            pv_last = tf_last; pv_row = row_idx;
            occ_m = occ_m + infl_m - int'(pop_b);
            infl_m = int'(ren);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_row();
        @(posedge clk); #1 row_rdy = 1'b1;
        @(posedge clk); #1 row_rdy = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        for (int r = 0; r < n && !abort; r++) begin
            int k = 0;
            while (buf_full && !abort && k < 4000) begin
                @(negedge clk); k++;
            end
            chk("feed_timeout", 64'(k >= 4000), 0);
            if (!abort) begin
                pulse_row();
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int max, input bit rnd);
        bit got = 0;
        for (int k = 0; k < max && !got; k++) begin
            @(posedge clk); #1;
            if (rnd) tf_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) got = 1;
        end
        chk("done_seen", 64'(got), 1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 0);
        tf_rdy = 1'b1;
    endtask

    task automatic pass_end(input int d0);
        chk("xfer_cnt", 64'(xfer), 1024);
        chk("last_cnt", 64'(lasts), 4);
        chk("done_cnt", 64'(done_cnt - d0), 1);
        chk("vld_idle", 64'(tf_vld), 0);
    endtask

    initial begin
        int d0;
        int k;
        rst_n = 1'b0; start = 1'b0; row_rdy = 1'b0; tf_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_buf_full", 64'(buf_full), 0);
        chk("rst_ren", 64'(ren), 0);
        chk("rst_addr", 64'(addr_r), 0);
        chk("rst_vld", 64'(tf_vld), 0);
        chk("rst_data", tf_data, 0);
        chk("rst_last", 64'(tf_last), 0);
        chk("rst_row", 64'(row_idx), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_stall", 64'(stall_cnt), 0);
        rst_n = 1'b1;
        tf_rdy = 1'b1;
        repeat (2) @(posedge clk);

        // Spaced rows, tf_rdy high.
        nb_row = 1; nb_x = 0;
        d0 = done_cnt;
        pulse_start();
        fork
            feed(4, 300);
            wait_done(3000, 0);
        join
        pass_end(d0);

        // Pre-loaded rows, overflow, release coincident with row_rdy.
        pulse_row();
        @(negedge clk);
        chk("full_one", 64'(buf_full), 0);
        pulse_row();
        @(negedge clk);
        chk("full_two", 64'(buf_full), 1);
        chk("err_before", 64'(err), 0);
        pulse_row();
        @(negedge clk);
        chk("err_set", 64'(err), 1);
        chk("full_ovf", 64'(buf_full), 1);
        nb_row = 1; nb_x = 1;
        d0 = done_cnt;
        pulse_start();
        fork
            begin
                k = 0;
                @(negedge clk);
                while (!(ren && addr_r[7:0] == 8'hFF) && k < 3000) begin
                    @(negedge clk); k++;
                end
                chk("rel_timeout", 64'(k >= 3000), 0);
                pulse_row();
                @(negedge clk);
                chk("full_coinc", 64'(buf_full), 1);
                chk("err_coinc", 64'(err), 1);
                feed(1, 0);
            end
            wait_done(3000, 0);
        join
        pass_end(d0);
        chk("err_sticky", 64'(err), 1);

        // Random back-pressure.
        nb_row = 0; nb_x = 0;
        d0 = done_cnt;
        pulse_start();
        fork
            feed(4, 0);
            wait_done(8000, 1);
        join
        pass_end(d0);

        // Reset in the middle of a pass.
        nb_row = 1; nb_x = 1;
        abort = 0;
        pulse_start();
        fork
            feed(4, 0);
        join_none
        k = 0;
        while (xfer < 500 && k < 3000) begin @(negedge clk); k++; end
        chk("x500_timeout", 64'(k >= 3000), 0);
        d0 = done_cnt;
        @(posedge clk); #1;
        abort = 1;
        rst_n = 1'b0;
        #1;
        chk("mid_buf_full", 64'(buf_full), 0);
        chk("mid_ren", 64'(ren), 0);
        chk("mid_addr", 64'(addr_r), 0);
        chk("mid_vld", 64'(tf_vld), 0);
        chk("mid_data", tf_data, 0);
        chk("mid_last", 64'(tf_last), 0);
        chk("mid_row", 64'(row_idx), 0);
        chk("mid_done", 64'(done), 0);
        chk("mid_err", 64'(err), 0);
        chk("mid_stall", 64'(stall_cnt), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done", 64'(done_cnt - d0), 0);
        abort = 0;
        d0 = done_cnt;
        pulse_start();
        fork
            feed(4, 0);
            wait_done(3000, 0);
        join
        pass_end(d0);

        // Ten stalled cycles with a valid word.
        nb_row = 0; nb_x = 0;
        tf_rdy = 1'b0;
        d0 = done_cnt;
        pulse_start();
        fork
            feed(4, 0);
        join_none
        k = 0;
        @(negedge clk);
        while (!tf_vld && k < 3000) begin @(negedge clk); k++; end
        chk("vld_timeout", 64'(k >= 3000), 0);
        repeat (10) @(posedge clk);
        #1 tf_rdy = 1'b1;
        @(negedge clk);
`ifdef TF_FETCH_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 10);
`else
        chk("stall_cnt", 64'(stall_cnt), 0);
`endif
        wait_done(3000, 0);
        pass_end(d0);
`ifdef TF_FETCH_STALL_CNT_EN
        chk("stall_hold", 64'(stall_cnt), 10);
`else
        chk("stall_hold", 64'(stall_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
